instr_dispatch: RTL
===================

INSTR_DISPATCH -- requirements
Module: instr_dispatch

Interface
REQ-001 SHALL have parameter WAIT_W, default 16, width of the WAIT-opcode cycle count.
REQ-002 SHALL have ports: clk  in  1  system clock (sys_clk domain); reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: instr_ready  in  1  instruction FIFO non-empty; instr_in  in  32  read-ahead FIFO head word; instr_ack  out  1  one-cycle pop strobe.
REQ-004 SHALL have ports: readback_ready  in  1  readback FIFO not full; readback_write  out  1  push strobe; readback_data  out  32  pushed word.
REQ-005 SHALL have ports: dac_request_write  out  1; dac_address  out  5; dac_data  out  12.
REQ-006 SHALL have ports: adc_request_write  out  1; adc_request_read  out  1; adc_address  out  11; adc_data  out  8; adc_data_readback  in  8.
REQ-007 SHALL have ports: spi_busy  in  1  SPI engine busy; cu_state  out  3  current state code; cu_instr  out  5  latched opcode.

Function
REQ-008 SHALL decode instr_in: opcode [31:27]; ADC address [26:16]; DAC address [20:16]; DAC data [11:0]; ADC data [7:0]; wait count [WAIT_W-1:0].
REQ-009 SHALL implement opcodes: 0x01 DAC_WRITE, 0x02 ADC_WRITE, 0x03 ADC_READ, 0x04 ECHO (push instr unchanged), 0x05 WAIT (idle count+1 cycles), 0x00 NOP; any other opcode SHALL push 0xDEAD_0000 | opcode.
REQ-010 SHALL use states IDLE=0, LATCH=1, ISSUE=2, BUSY_WAIT=3, BUSY_DONE=4, PUSH=5, DELAY=6; cu_state SHALL equal the state code.
REQ-011 IDLE -> LATCH when instr_ready=1; LATCH latches instr_in into an internal register, asserts instr_ack for exactly that cycle, sets cu_instr.
REQ-012 From LATCH: SPI opcodes -> ISSUE; ECHO and unknown -> PUSH; WAIT -> DELAY; NOP -> IDLE.
REQ-013 ISSUE SHALL hold until spi_busy=0, then assert exactly one request strobe for one cycle and go to BUSY_WAIT; address/data outputs SHALL be stable from ISSUE until return to IDLE.
REQ-014 BUSY_WAIT -> BUSY_DONE on spi_busy=1; if spi_busy stays 0 for 255 cycles, SHALL proceed to BUSY_DONE anyway (timeout) and set readback word bit 26 on ADC_READ.
REQ-015 BUSY_DONE SHALL wait for spi_busy=0; ADC_READ then captures adc_data_readback and -> PUSH; writes -> IDLE.
REQ-016 ADC_READ readback word SHALL be {5'h03, timeout flag, 2'b0, 5'b0, adc_address, adc_data_readback} with address in [18:8].
REQ-017 PUSH SHALL assert readback_write for one cycle only when readback_ready=1, otherwise stall in PUSH; readback_data valid during the strobe; -> IDLE.
REQ-018 DELAY SHALL count count+1 cycles, count=0 giving one cycle, then -> IDLE.
REQ-019 Minimum instruction throughput: NOP SHALL consume 2 cycles (IDLE, LATCH); back-to-back instructions SHALL never double-ack or skip a word.
REQ-020 instr_ready dropping after LATCH SHALL not affect the in-flight instruction.

Reset
REQ-021 reset_n=0 SHALL asynchronously force IDLE, all strobes 0, all address/data outputs 0, cu_instr 0, counters 0, timeout flag 0.
REQ-022 Reset mid-operation SHALL abandon the instruction without any further ack, request or push; release SHALL be synchronized (two-flop) internally.

Structure
REQ-023 Opcode codes, state codes, field bit positions and 0xDEAD error prefix SHALL live in a shared package daq_pkg.
REQ-024 One sub-module SHALL be natural: spi_handshake (ISSUE/BUSY_WAIT/BUSY_DONE sequencing plus 8-bit timeout counter).

Verification
REQ-025 Push 0x0812_0ABC (DAC_WRITE addr 0x12, data 0xABC), model spi_busy 3 cycles after strobe -> one dac_request_write pulse, dac_address=0x12, dac_data=0xABC, no readback.
REQ-026 Push ADC_READ addr 0x155, model returns 0x5A -> one adc_request_read, readback word 0x1801_555A.
REQ-027 Push ECHO 0x2000_1234 with readback_ready=0 for 10 cycles -> stall in PUSH, single push of 0x2000_1234 after ready rises.
REQ-028 Push 0xF800_0000 -> readback 0xDEAD_001F; push WAIT count 5 -> 6 cycles in DELAY then IDLE.
REQ-029 ADC_READ with spi_busy never asserted -> timeout after 255 cycles, readback bit 26=1.
REQ-030 Assert reset_n low during BUSY_WAIT -> all outputs 0 same cycle, next instruction after release processed normally.

Source files
------------

// File: rtl/daq_pkg.sv
// rtl/daq_pkg.sv - shared codes, field positions and word builders for instr_dispatch
//
// Purpose: single home for opcode values, control-unit state codes, instruction
//          field bit positions, the error prefix and the SPI busy timeout limit.
// Ports:   none (package).
package daq_pkg;

  // Opcodes carried in instr[31:27]
  localparam logic [4:0] OP_NOP       = 5'h00;
  localparam logic [4:0] OP_DAC_WRITE = 5'h01;
  localparam logic [4:0] OP_ADC_WRITE = 5'h02;
  localparam logic [4:0] OP_ADC_READ  = 5'h03;
  localparam logic [4:0] OP_ECHO      = 5'h04;
  localparam logic [4:0] OP_WAIT      = 5'h05;

  // Control-unit states; the encoding is visible on cu_state
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LATCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_BUSY_WAIT = 3'd3,
    ST_BUSY_DONE = 3'd4,
    ST_PUSH      = 3'd5,
    ST_DELAY     = 3'd6
  } state_e;

  // Instruction field positions
  localparam int OPCODE_MSB   = 31;
  localparam int OPCODE_LSB   = 27;
  localparam int ADC_ADDR_MSB = 26;
  localparam int ADC_ADDR_LSB = 16;
  localparam int DAC_ADDR_MSB = 20;
  localparam int DAC_ADDR_LSB = 16;
  localparam int DAC_DATA_MSB = 11;
  localparam int ADC_DATA_MSB = 7;

  localparam logic [15:0] ERR_PREFIX = 16'hDEAD;

  // BUSY_WAIT gives up on the cycle where the counter reads this value,
  // i.e. after 255 cycles without seeing spi_busy.
  localparam logic [7:0] SPI_TIMEOUT_LAST = 8'd254;

  function automatic logic [31:0] adc_readback_word(input logic        timeout,
                                                    input logic [10:0] addr,
                                                    input logic [7:0]  data);
    return {OP_ADC_READ, timeout, 2'b00, 5'b00000, addr, data};
  endfunction

  function automatic logic [31:0] error_word(input logic [4:0] op);
    return {ERR_PREFIX, 11'd0, op};
  endfunction

endpackage

// File: rtl/spi_handshake.sv
// rtl/spi_handshake.sv - ISSUE/BUSY_WAIT/BUSY_DONE sequencing with busy timeout
//
// Purpose: decides when a request may fire, when the SPI engine has been seen
//          busy (or timed out), and when it has gone idle again.
// Ports:   clk_i, rst_n_i       clock, synchronized active-low reset
//          state_i              current control-unit state
//          spi_busy_i           SPI engine busy
//          req_fire_o           fire the request strobe this cycle (ISSUE)
//          advance_o            leave BUSY_WAIT this cycle
//          done_o               leave BUSY_DONE this cycle
//          timeout_o            last BUSY_WAIT ended by timeout
module spi_handshake
  import daq_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  state_e state_i,
  input  logic   spi_busy_i,
  output logic   req_fire_o,
  output logic   advance_o,
  output logic   done_o,
  output logic   timeout_o
);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  always_comb begin
    req_fire_o = 1'b0;
    advance_o  = 1'b0;
    done_o     = 1'b0;
    cnt_d      = 8'd0;
    timeout_d  = timeout_q;
    case (state_i)
      ST_ISSUE: begin
        req_fire_o = !spi_busy_i;
        timeout_d  = 1'b0;
      end
      ST_BUSY_WAIT: begin
        if (spi_busy_i) begin
          advance_o = 1'b1;
        end else if (cnt_q == SPI_TIMEOUT_LAST) begin
          advance_o = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_BUSY_DONE: done_o = !spi_busy_i;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/instr_dispatch.sv
// rtl/instr_dispatch.sv - instruction FIFO dispatcher for DAC/ADC SPI ops and readback
//
// Purpose: pops 32-bit instructions, issues DAC/ADC SPI requests, echoes words,
//          reports unknown opcodes and executes timed waits.
// Ports:   clk, reset_n                                     clock, async active-low reset
//          instr_ready, instr_in, instr_ack                 instruction FIFO (read-ahead)
//          readback_ready, readback_write, readback_data    readback FIFO push side
//          dac_request_write, dac_address, dac_data         DAC SPI request
//          adc_request_write, adc_request_read, adc_address,
//          adc_data, adc_data_readback                      ADC SPI request/response
//          spi_busy                                         SPI engine busy
//          cu_state, cu_instr                               state code, latched opcode
module instr_dispatch
  import daq_pkg::*;
#(
  parameter int WAIT_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_ready,
  input  logic [31:0] instr_in,
  output logic        instr_ack,
  input  logic        readback_ready,
  output logic        readback_write,
  output logic [31:0] readback_data,
  output logic        dac_request_write,
  output logic [4:0]  dac_address,
  output logic [11:0] dac_data,
  output logic        adc_request_write,
  output logic        adc_request_read,
  output logic [10:0] adc_address,
  output logic [7:0]  adc_data,
  input  logic [7:0]  adc_data_readback,
  input  logic        spi_busy,
  output logic [2:0]  cu_state,
  output logic [4:0]  cu_instr
);

  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  // Assertion is immediate; release passes through two flops so every
  // register leaves reset on the same clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [4:0]        opcode_q, opcode_d;
  logic [4:0]        dac_addr_q, dac_addr_d;
  logic [11:0]       dac_data_q, dac_data_d;
  logic [10:0]       adc_addr_q, adc_addr_d;
  logic [7:0]        adc_data_q, adc_data_d;
  logic [31:0]       rb_q, rb_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic       req_fire, advance, done, timeout;
  logic [4:0] op_in;

  assign op_in = instr_in[OPCODE_MSB:OPCODE_LSB];

  spi_handshake u_spi_handshake (
    .clk_i      (clk),
    .rst_n_i    (rst_n_int),
    .state_i    (state_q),
    .spi_busy_i (spi_busy),
    .req_fire_o (req_fire),
    .advance_o  (advance),
    .done_o     (done),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d           = state_q;
    opcode_d          = opcode_q;
    dac_addr_d        = dac_addr_q;
    dac_data_d        = dac_data_q;
    adc_addr_d        = adc_addr_q;
    adc_data_d        = adc_data_q;
    rb_d              = rb_q;
    wait_cnt_d        = wait_cnt_q;
    instr_ack         = 1'b0;
    readback_write    = 1'b0;
    dac_request_write = 1'b0;
    adc_request_write = 1'b0;
    adc_request_read  = 1'b0;
    case (state_q)
      ST_IDLE: if (instr_ready) state_d = ST_LATCH;
      ST_LATCH: begin
        // The FIFO head is decoded directly here; the pop takes effect at
        // the end of this cycle, so instr_ready no longer matters.
        instr_ack = 1'b1;
        opcode_d  = op_in;
        case (op_in)
          OP_NOP: state_d = ST_IDLE;
          OP_DAC_WRITE: begin
            dac_addr_d = instr_in[DAC_ADDR_MSB:DAC_ADDR_LSB];
            dac_data_d = instr_in[DAC_DATA_MSB:0];
            state_d    = ST_ISSUE;
          end
          OP_ADC_WRITE, OP_ADC_READ: begin
            adc_addr_d = instr_in[ADC_ADDR_MSB:ADC_ADDR_LSB];
            adc_data_d = instr_in[ADC_DATA_MSB:0];
            state_d    = ST_ISSUE;
          end
          OP_ECHO: begin
            rb_d    = instr_in;
            state_d = ST_PUSH;
          end
          OP_WAIT: begin
            wait_cnt_d = instr_in[WAIT_W-1:0];
            state_d    = ST_DELAY;
          end
          default: begin
            rb_d    = error_word(op_in);
            state_d = ST_PUSH;
          end
        endcase
      end
      ST_ISSUE: begin
        if (req_fire) begin
          dac_request_write = (opcode_q == OP_DAC_WRITE);
          adc_request_write = (opcode_q == OP_ADC_WRITE);
          adc_request_read  = (opcode_q == OP_ADC_READ);
          state_d           = ST_BUSY_WAIT;
        end
      end
      ST_BUSY_WAIT: if (advance) state_d = ST_BUSY_DONE;
      ST_BUSY_DONE: begin
        if (done) begin
          if (opcode_q == OP_ADC_READ) begin
            rb_d    = adc_readback_word(timeout, adc_addr_q, adc_data_readback);
            state_d = ST_PUSH;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PUSH: begin
        if (readback_ready) begin
          readback_write = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (wait_cnt_q == '0) state_d = ST_IDLE;
        else                  wait_cnt_d = wait_cnt_q - WAIT_ONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      opcode_q   <= 5'd0;
      dac_addr_q <= 5'd0;
      dac_data_q <= 12'd0;
      adc_addr_q <= 11'd0;
      adc_data_q <= 8'd0;
      rb_q       <= 32'd0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      dac_addr_q <= dac_addr_d;
      dac_data_q <= dac_data_d;
      adc_addr_q <= adc_addr_d;
      adc_data_q <= adc_data_d;
      rb_q       <= rb_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign readback_data = rb_q;
  assign dac_address   = dac_addr_q;
  assign dac_data      = dac_data_q;
  assign adc_address   = adc_addr_q;
  assign adc_data      = adc_data_q;
  assign cu_state      = state_q;
  assign cu_instr      = opcode_q;

endmodule
